// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/result bundle for seq_divider
interface seq_divider_if #(
   parameter int N = 32
);
   logic           start;
   logic [2*N-1:0] A;
   logic [N-1:0]   B;
   logic           busy;
   logic           done;
   logic [N-1:0]   quotient;
   logic [N-1:0]   remainder;
   logic           div_by_zero;
   logic           overflow;

   modport master (
      output start, A, B,
      input  busy, done, quotient, remainder, div_by_zero, overflow
   );

   modport slave (
      input  start, A, B,
      output busy, done, quotient, remainder, div_by_zero, overflow
   );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - radix-2 restoring 2N/N divider, signed when SEQ_DIV_SIGNED_EN is defined
module seq_divider #(
   parameter int N = 32
) (
   input logic         clk,
   input logic         reset,
   seq_divider_if.slave bus
);
   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t         state;
   logic [2*N-1:0] acc;      // {partial remainder, dividend low bits / quotient bits}
   logic [N-1:0]   b_mag;
   logic [CW-1:0]  cnt;

   logic [2*N-1:0] a_abs;
   logic [N-1:0]   b_abs;
   logic [N:0]     trial;
   logic [2*N-1:0] acc_next;

`ifdef SEQ_DIV_SIGNED_EN
   localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};
   logic         sign_a;
   logic         sign_q;
   logic [N-1:0] q_mag;
   logic [N-1:0] r_mag;
   logic [N-1:0] q_fix;
   logic [N-1:0] r_fix;
   logic         ovf_fix;

   // Sign correction of the magnitude result; quotient range depends on result sign
   always_comb begin
      q_mag   = acc[N-1:0];
      r_mag   = acc[2*N-1:N];
      q_fix   = sign_q ? -q_mag : q_mag;
      r_fix   = sign_a ? -r_mag : r_mag;
      ovf_fix = sign_q ? (q_mag > HALF) : q_mag[N-1];
   end
`endif

   // Operand magnitudes and one restoring shift/subtract step
   always_comb begin
`ifdef SEQ_DIV_SIGNED_EN
      a_abs = bus.A[2*N-1] ? -bus.A : bus.A;
      b_abs = bus.B[N-1] ? -bus.B : bus.B;
`else
      a_abs = bus.A;
      b_abs = bus.B;
`endif
      // Partial remainder shifted left by one is acc[2N-1:N-1]; it is < 2*|B| so N+1 bits suffice
      trial = acc[2*N-1:N-1] - {1'b0, b_mag};
      if (!trial[N]) begin
         acc_next = {trial[N-1:0], acc[N-2:0], 1'b1};
      end else begin
         acc_next = {acc[2*N-2:0], 1'b0};
      end
   end

   // Control FSM with registered busy/done and result registers held between done pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         acc             <= '0;
         b_mag           <= '0;
         cnt             <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.div_by_zero <= 1'b0;
         bus.overflow    <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
         sign_a          <= 1'b0;
         sign_q          <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  acc   <= a_abs;
                  b_mag <= b_abs;
                  cnt   <= '0;
`ifdef SEQ_DIV_SIGNED_EN
                  sign_a <= bus.A[2*N-1];
                  sign_q <= bus.A[2*N-1] ^ bus.B[N-1];
`endif
                  if (b_abs == '0) begin
                     state           <= DONE;
                     bus.done        <= 1'b1;
                     bus.div_by_zero <= 1'b1;
                     bus.overflow    <= 1'b0;
                     bus.quotient    <= '1;
                     bus.remainder   <= bus.A[N-1:0];
                  end else if (a_abs[2*N-1:N] >= b_abs) begin
                     // Quotient cannot fit in N bits even as a magnitude
                     state           <= DONE;
                     bus.done        <= 1'b1;
                     bus.div_by_zero <= 1'b0;
                     bus.overflow    <= 1'b1;
                     bus.quotient    <= '1;
                     bus.remainder   <= '0;
                  end else begin
                     state    <= RUN;
                     bus.busy <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
`ifdef SEQ_DIV_SIGNED_EN
                  state <= FIX;
`else
                  state           <= DONE;
                  bus.busy        <= 1'b0;
                  bus.done        <= 1'b1;
                  bus.quotient    <= acc_next[N-1:0];
                  bus.remainder   <= acc_next[2*N-1:N];
                  bus.div_by_zero <= 1'b0;
                  bus.overflow    <= 1'b0;
`endif
               end
            end
`ifdef SEQ_DIV_SIGNED_EN
            FIX: begin
               state           <= DONE;
               bus.busy        <= 1'b0;
               bus.done        <= 1'b1;
               bus.quotient    <= q_fix;
               bus.remainder   <= r_fix;
               bus.div_by_zero <= 1'b0;
               bus.overflow    <= ovf_fix;
            end
`endif
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule
